ula_ctrl: RTL and testbench

ULA_CTRL -- requirements
Module: ula_ctrl

---
 rtl/ula_ctrl.sv | 156 +++++++++++++++
 tb/tb_ula_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ula_ctrl.sv
// ula_ctrl: sequencer for an external 8-bit ALU; ULA_CTRL_MUL_EN enables shift-add MUL for op 111.
module ula_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] op,
  input  logic [7:0] opa,
  input  logic [7:0] opb,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] result,
  output logic       carry,
  output logic       zero,
  output logic       err,
  output logic       F0,
  output logic       F1,
  output logic       ENA,
  output logic       ENB,
  output logic       INVA,
  output logic       INC,
  output logic [7:0] A,
  output logic [7:0] B,
  input  logic [7:0] alu_out,
  input  logic       alu_cout
);
  typedef enum logic [2:0] {
    IDLE,
    EXEC,
`ifdef ULA_CTRL_MUL_EN
    MUL_DBL,
    MUL_ADD,
`endif
    DONE
  } state_t;
  state_t state, state_nx;
  logic [2:0] op_r;
  logic [7:0] a_r, b_r;
  logic [5:0] cw;
`ifdef ULA_CTRL_MUL_EN
  logic [7:0] acc;
  logic [2:0] idx;
`endif
  assign req_ready = state == IDLE;
  assign rsp_valid = state == DONE;
  assign {F0, F1, ENA, ENB, INVA, INC} = cw;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next-state logic; op 111 without MUL takes the EXEC slot with the ALU idle and reports err
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_valid) state_nx = EXEC;
`ifdef ULA_CTRL_MUL_EN
        if (req_valid && (&op)) state_nx = MUL_DBL;
`endif
      end
      EXEC: state_nx = DONE;
`ifdef ULA_CTRL_MUL_EN
      MUL_DBL: state_nx = MUL_ADD;
      MUL_ADD: state_nx = (idx == 3'd0) ? DONE : MUL_DBL;
`endif
      DONE: state_nx = rsp_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // ALU control word and operand buses; everything idles at zero outside ALU cycles
  always_comb begin
    cw = '0;
    A = '0;
    B = '0;
    case (state)
      EXEC: begin
        case (op_r)
          3'd0: cw = 6'b001100;
          3'd1: cw = 6'b011100;
          3'd2: cw = 6'b101100;
          3'd3: cw = 6'b111100;
          3'd4: cw = 6'b111101;
          3'd5: cw = 6'b111111;
          3'd6: cw = 6'b110110;
          default: cw = '0;
        endcase
        A = (&op_r) ? 8'h00 : a_r;
        B = (&op_r) ? 8'h00 : b_r;
      end
`ifdef ULA_CTRL_MUL_EN
      MUL_DBL: begin
        cw = 6'b111100;
        A = acc;
        B = acc;
      end
      MUL_ADD: begin
        cw = {2'b11, b_r[idx], 3'b100};
        A = a_r;
        B = acc;
      end
`endif
      default: cw = '0;
    endcase
  end
  // operand capture, accumulator and response registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      result <= '0;
      carry <= 1'b0;
      zero <= 1'b0;
      err <= 1'b0;
`ifdef ULA_CTRL_MUL_EN
      acc <= '0;
      idx <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op_r <= op;
          a_r <= opa;
          b_r <= opb;
`ifdef ULA_CTRL_MUL_EN
          acc <= '0;
          idx <= 3'd7;
          carry <= 1'b0;
`endif
        end
        EXEC: begin
          result <= (&op_r) ? 8'h00 : alu_out;
          carry <= !(&op_r) && alu_cout;
          zero <= (&op_r) || (alu_out == 8'h00);
          err <= &op_r;
        end
`ifdef ULA_CTRL_MUL_EN
        MUL_DBL: begin
          acc <= alu_out;
          carry <= carry | alu_cout;
        end
        MUL_ADD: begin
          acc <= alu_out;
          carry <= carry | alu_cout;
          idx <= idx - 3'd1;
          if (idx == 3'd0) begin
            result <= alu_out;
            zero <= alu_out == 8'h00;
            err <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
endmodule

// File: tb/tb_ula_ctrl.sv
// tb_ula_ctrl: randomized and directed checks of ula_ctrl against an arithmetic reference model.
module tb_ula_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, rsp_ready = 1'b0;
  logic [2:0] op = '0;
  logic [7:0] opa = '0, opb = '0;
  logic req_ready, rsp_valid, carry, zero, err, F0, F1, ENA, ENB, INVA, INC, alu_cout;
  logic [7:0] result, A, B, alu_out;
  logic [7:0] a_e, b_e;
  logic [8:0] s;
  logic [5:0] cw;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign cw = {F0, F1, ENA, ENB, INVA, INC};
  ula_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .op(op),
    .opa(opa), .opb(opb), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .result(result),
    .carry(carry), .zero(zero), .err(err), .F0(F0), .F1(F1), .ENA(ENA), .ENB(ENB),
    .INVA(INVA), .INC(INC), .A(A), .B(B), .alu_out(alu_out), .alu_cout(alu_cout)
  );
  // external 8-bit ALU: F0F1 selects AND/OR/NOT B/ADD over gated and optionally inverted operands
  always_comb begin
    a_e = ENA ? A : 8'h00;
    if (INVA) a_e = ~a_e;
    b_e = ENB ? B : 8'h00;
    s = {1'b0, a_e} + {1'b0, b_e} + {8'h00, INC};
    alu_out = ({F0, F1} == 2'b00) ? (a_e & b_e) : ({F0, F1} == 2'b01) ? (a_e | b_e) :
              ({F0, F1} == 2'b10) ? ~b_e : s[7:0];
    alu_cout = ({F0, F1} == 2'b11) && s[8];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // returns {err, zero, carry, result}
  function automatic logic [10:0] model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    int t;
    logic [7:0] r;
    logic c, e;
    c = 1'b0;
    e = 1'b0;
    t = 0;
    case (o)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = ~b;
      3'd3: begin t = int'(a) + int'(b); r = 8'(t); c = t > 255; end
      3'd4: begin t = int'(a) + int'(b) + 1; r = 8'(t); c = t > 255; end
      3'd5: begin r = b - a; c = b >= a; end
      3'd6: begin r = b - 8'd1; c = b != 8'd0; end
      default: begin
`ifdef ULA_CTRL_MUL_EN
        t = int'(a) * int'(b);
        r = 8'(t);
        c = t > 255;
`else
        r = 8'h00;
        e = 1'b1;
`endif
      end
    endcase
    return {e, r == 8'h00, c, r};
  endfunction
  function automatic logic [5:0] cw_of(input logic [2:0] o);
    case (o)
      3'd0: return 6'b001100;
      3'd1: return 6'b011100;
      3'd2: return 6'b101100;
      3'd3: return 6'b111100;
      3'd4: return 6'b111101;
      3'd5: return 6'b111111;
      3'd6: return 6'b110110;
      default: return 6'b000000;
    endcase
  endfunction
  function automatic int lat_of(input logic [2:0] o);
`ifdef ULA_CTRL_MUL_EN
    return (o == 3'd7) ? 17 : 2;
`else
    return (o == 3'd7) ? 2 : 2;
`endif
  endfunction
  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [10:0] e;
    int lat;
    e = model(o, a, b);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    op = o;
    opa = a;
    opb = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    op = 3'($urandom);
    opa = 8'($urandom);
    opb = 8'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      if (lat == 1 && o != 3'd7) begin
        chk("exec_cw", cw, cw_of(o));
        chk("exec_a", A, a);
        chk("exec_b", B, b);
      end
`ifdef ULA_CTRL_MUL_EN
      if (lat == 1 && o == 3'd7) chk("mul_first_dbl", {cw, A, B}, {6'b111100, 16'h0000});
`else
      if (o == 3'd7) chk("err_alu_idle", {cw, A, B}, 0);
`endif
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, lat_of(o));
    for (int i = 0; i < hold; i++) begin
      chk("hold_result", {err, zero, carry, result}, e);
      chk("hold_ready", {req_ready, rsp_valid}, 2'b01);
      req_valid = 1'($urandom);
      op = 3'($urandom);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("result", result, e[7:0]);
    chk("carry", carry, e[8]);
    chk("zero", zero, e[9]);
    chk("err", err, e[10]);
    chk("done_alu_idle", {cw, A, B}, 0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("after_handshake", {req_ready, rsp_valid}, 2'b10);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    #3;
    chk("reset_state", {req_ready, rsp_valid, result, carry, zero, err, cw, A, B}, {2'b10, 8'h00, 3'b000, 22'h0});
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd3, 8'hFF, 8'h01, 0);
    run_op(3'd5, 8'h05, 8'h03, 0);
    run_op(3'd6, 8'h5A, 8'h00, 0);
    run_op(3'd4, 8'h10, 8'h20, 0);
    run_op(3'd0, 8'hF0, 8'h3C, 0);
    run_op(3'd1, 8'hA0, 8'h05, 0);
    run_op(3'd2, 8'h00, 8'hFF, 0);
    run_op(3'd7, 8'h0C, 8'h0B, 0);
    run_op(3'd7, 8'h10, 8'h10, 0);
    run_op(3'd3, 8'h11, 8'h22, 5);
    run_op(3'd7, 8'hFF, 8'hFF, 5);
    @(negedge clk);
    req_valid = 1'b1;
`ifdef ULA_CTRL_MUL_EN
    op = 3'd7;
`else
    op = 3'd3;
`endif
    opa = 8'h0C;
    opb = 8'h0B;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
`ifdef ULA_CTRL_MUL_EN
    repeat (7) @(negedge clk);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("midop_reset", {req_ready, rsp_valid, result, carry, zero, err, cw, A, B}, {2'b10, 8'h00, 3'b000, 22'h0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("no_rsp_after_abort", {req_ready, rsp_valid}, 2'b10);
      @(negedge clk);
    end
    run_op(3'd3, 8'h01, 8'h02, 0);
    for (int i = 0; i < 40; i++)
      run_op(3'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
